// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game datapath: play-field bounds,
// grid pitch, body array sizing, food reset position and placer state encoding.
package snake_pkg;

  localparam int COORD_W = 10;
  localparam int GRID    = 10;
  localparam int MAX_LEN = 32;
  localparam int IDX_W   = $clog2(MAX_LEN);

  localparam logic [COORD_W-1:0] X_MIN = 10'd20;
  localparam logic [COORD_W-1:0] X_MAX = 10'd620;
  localparam logic [COORD_W-1:0] Y_MIN = 10'd20;
  localparam logic [COORD_W-1:0] Y_MAX = 10'd460;

  localparam logic [COORD_W-1:0] FOOD_RST_X = 10'd320;
  localparam logic [COORD_W-1:0] FOOD_RST_Y = 10'd240;

  localparam int                 RETRY_W   = 4;
  localparam logic [RETRY_W-1:0] MAX_TRIES = 4'd15;

  typedef enum logic [1:0] {
    SAMPLE = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2,
    HOLD   = 2'd3
  } place_state_t;

endpackage

// File: rtl/coord_in_bounds.sv
// Combinational play-field check: high when (x, y) lies inside the legal area.
// Shared by the food placer and the snake head wall-collision logic.
module coord_in_bounds
  import snake_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               in_bounds
);

  assign in_bounds = (x >= X_MIN) && (x <= X_MAX) &&
                     (y >= Y_MIN) && (y <= Y_MAX);

endmodule

// File: rtl/food_placer.sv
// Food placer: samples a random candidate, rejects it if it lies outside the
// play field or on any snake segment (scanned one segment per cycle), and
// latches the first clean candidate as the food position until it is eaten.
module food_placer
  import snake_pkg::*;
(
  input  logic               VGAclk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] rX,
  input  logic [COORD_W-1:0] rY,
  input  logic               eat,
  input  logic [IDX_W:0]     snake_len,
  output logic [IDX_W-1:0]   seg_idx,
  input  logic [COORD_W-1:0] seg_x,
  input  logic [COORD_W-1:0] seg_y,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               placed,
  output logic               busy,
  output logic               place_err
);

  place_state_t       state, state_next;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic [RETRY_W-1:0] retries, retries_inc;
  logic               cand_ok, seg_hit, scan_past_end, scan_last, reject;

  coord_in_bounds u_bounds (
    .x         (rX),
    .y         (rY),
    .in_bounds (cand_ok)
  );

  assign seg_hit       = (seg_x == cand_x) && (seg_y == cand_y);
  // The scan follows the live snake_len, so an index at or past it ends the scan.
  assign scan_past_end = ({1'b0, seg_idx} >= snake_len);
  assign scan_last     = (({1'b0, seg_idx} + (IDX_W+1)'(1)) == snake_len);
  assign retries_inc   = (retries == '1) ? retries : retries + RETRY_W'(1);

  // State register.
  always_ff @(posedge VGAclk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= SAMPLE;
    else        state <= state_next;
  end

  // Next-state decode and rejection detect.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_next = state;
    reject     = 1'b0;
    case (state)
      SAMPLE: begin
        if (!cand_ok)              reject     = 1'b1;
        else if (snake_len == '0)  state_next = COMMIT;
        else                       state_next = SCAN;
      end
      SCAN: begin
        if (scan_past_end) begin
          state_next = COMMIT;
        end else if (seg_hit) begin
          state_next = SAMPLE;
          reject     = 1'b1;
        end else if (scan_last) begin
          state_next = COMMIT;
        end
      end
      COMMIT:  state_next = HOLD;
      HOLD:    if (eat) state_next = SAMPLE;
      default: state_next = SAMPLE;
    endcase
  end

  // Candidate, scan index, food position, retry budget and status flags.
  always_ff @(posedge VGAclk or negedge rst_n) begin
    if (!rst_n) begin
      cand_x     <= '0;
      cand_y     <= '0;
      seg_idx    <= '0;
      retries    <= '0;
      food_x     <= FOOD_RST_X;
      food_y     <= FOOD_RST_Y;
      food_valid <= 1'b0;
      placed     <= 1'b0;
      busy       <= 1'b1;
      place_err  <= 1'b0;
    end else begin
      placed <= 1'b0;
      busy   <= (state_next != HOLD);
      case (state)
        SAMPLE: begin
          cand_x  <= rX;
          cand_y  <= rY;
          seg_idx <= '0;
        end
        SCAN: begin
          if (!scan_past_end && !seg_hit && !scan_last) seg_idx <= seg_idx + IDX_W'(1);
        end
        COMMIT: begin
          food_x     <= cand_x;
          food_y     <= cand_y;
          food_valid <= 1'b1;
          placed     <= 1'b1;
        end
        HOLD: begin
          if (eat) food_valid <= 1'b0;
        end
        default: ;
      endcase
      // Retry budget: saturating count of consecutive rejections; the error
      // flag is sticky until the next successful placement.
      if (state == COMMIT) begin
        retries   <= '0;
        place_err <= 1'b0;
      end else if (reject) begin
        retries <= retries_inc;
        if (retries_inc >= MAX_TRIES) place_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// Self-checking bench for food_placer: reset state, placement latency for a
// table of clean candidates, and hand-written sequences for segment hits,
// retry exhaustion, ignored eat pulses and reset in the middle of a scan.
module tb_food_placer;
  import snake_pkg::*;

  logic               VGAclk = 1'b0;
  logic               rst_n;
  logic [COORD_W-1:0] rX, rY;
  logic               eat;
  logic [IDX_W:0]     snake_len;
  logic [IDX_W-1:0]   seg_idx;
  logic [COORD_W-1:0] seg_x, seg_y;
  logic [COORD_W-1:0] food_x, food_y;
  logic               food_valid, placed, busy, place_err;

  // Snake body model: segment i sits at (100 + 10*i, 200).
  logic [COORD_W-1:0] body_x [MAX_LEN];
  logic [COORD_W-1:0] body_y [MAX_LEN];
  assign seg_x = body_x[seg_idx];
  assign seg_y = body_y[seg_idx];

  int n_tests = 0;
  int n_fail  = 0;

  food_placer dut (
    .VGAclk     (VGAclk),
    .rst_n      (rst_n),
    .rX         (rX),
    .rY         (rY),
    .eat        (eat),
    .snake_len  (snake_len),
    .seg_idx    (seg_idx),
    .seg_x      (seg_x),
    .seg_y      (seg_y),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .placed     (placed),
    .busy       (busy),
    .place_err  (place_err)
  );

  always #5 VGAclk = ~VGAclk;

  typedef struct {
    logic [COORD_W-1:0] rx;
    logic [COORD_W-1:0] ry;
    logic [IDX_W:0]     len;
    int                 lat;    // edges from the eat edge to placed
    logic [COORD_W-1:0] exp_x;
    logic [COORD_W-1:0] exp_y;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge VGAclk);
    #1;
  endtask

  // Count edges until placed is seen; the bound turns a hang into a failure.
  task automatic wait_placed(input string name, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (placed) break;
    end
    if (!placed) check({name, "_timeout"}, 32'(placed), 32'd1);
  endtask

  // One-cycle eat pulse; returns just after the edge that samples it.
  task automatic pulse_eat();
    eat = 1'b1;
    tick();
    eat = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;

    for (int i = 0; i < MAX_LEN; i++) begin
      body_x[i] = COORD_W'(100 + 10 * i);
      body_y[i] = 10'd200;
    end

    vecs[0] = '{rx: 10'd300, ry: 10'd300, len: 6'd3,  lat: 5,  exp_x: 10'd300, exp_y: 10'd300};
    vecs[1] = '{rx: 10'd20,  ry: 10'd20,  len: 6'd1,  lat: 3,  exp_x: 10'd20,  exp_y: 10'd20};
    vecs[2] = '{rx: 10'd620, ry: 10'd460, len: 6'd0,  lat: 2,  exp_x: 10'd620, exp_y: 10'd460};
    vecs[3] = '{rx: 10'd130, ry: 10'd210, len: 6'd4,  lat: 6,  exp_x: 10'd130, exp_y: 10'd210};
    vecs[4] = '{rx: 10'd410, ry: 10'd210, len: 6'd32, lat: 34, exp_x: 10'd410, exp_y: 10'd210};

    // Reset values, then automatic placement with an empty snake.
    rst_n = 1'b0; eat = 1'b0; snake_len = '0; rX = 10'd100; rY = 10'd200;
    tick(); tick();
    check("rst_food_x", 32'(food_x), 32'd320);
    check("rst_food_y", 32'(food_y), 32'd240);
    check("rst_valid", 32'(food_valid), 32'd0);
    check("rst_placed", 32'(placed), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_err", 32'(place_err), 32'd0);
    check("rst_seg_idx", 32'(seg_idx), 32'd0);
    rst_n = 1'b1;
    wait_placed("init", n);
    check("init_latency", 32'(n), 32'd2);
    check("init_valid", 32'(food_valid), 32'd1);
    check("init_food_x", 32'(food_x), 32'd100);
    check("init_food_y", 32'(food_y), 32'd200);
    tick();
    check("init_placed_pulse", 32'(placed), 32'd0);
    check("init_busy_hold", 32'(busy), 32'd0);

    // Segment-by-segment scan with three segments and a clean candidate.
    snake_len = 6'd3; rX = 10'd300; rY = 10'd300;
    pulse_eat();
    check("step_valid_drop", 32'(food_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("step_idx%0d", k), 32'(seg_idx), 32'(k));
    end
    tick();
    check("step_commit_no_placed", 32'(placed), 32'd0);
    tick();
    check("step_placed", 32'(placed), 32'd1);
    check("step_food_x", 32'(food_x), 32'd300);
    check("step_food_y", 32'(food_y), 32'd300);

    // Table of clean candidates: latency L+2 edges from the eat edge.
    foreach (vecs[v]) begin
      snake_len = vecs[v].len; rX = vecs[v].rx; rY = vecs[v].ry;
      pulse_eat();
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'd1);
      check($sformatf("vec%0d_valid_drop", v), 32'(food_valid), 32'd0);
      wait_placed($sformatf("vec%0d", v), n);
      check($sformatf("vec%0d_latency", v), 32'(n), 32'(vecs[v].lat));
      check($sformatf("vec%0d_food_x", v), 32'(food_x), 32'(vecs[v].exp_x));
      check($sformatf("vec%0d_food_y", v), 32'(food_y), 32'(vecs[v].exp_y));
      check($sformatf("vec%0d_valid", v), 32'(food_valid), 32'd1);
      check($sformatf("vec%0d_busy_hold", v), 32'(busy), 32'd0);
    end

    // Candidate on segment 1 aborts the scan, then (50,50) is committed.
    snake_len = 6'd3; rX = 10'd110; rY = 10'd200;
    pulse_eat();
    tick();                       // candidate (110,200) latched
    rX = 10'd50; rY = 10'd50;
    tick();
    check("hit_idx1", 32'(seg_idx), 32'd1);
    tick();                       // hit on segment 1, back to SAMPLE
    check("hit_abort_idx", 32'(seg_idx), 32'd1);
    check("hit_busy", 32'(busy), 32'd1);
    wait_placed("hit", n);
    check("hit_latency", 32'(n + 3), 32'd8);
    check("hit_food_x", 32'(food_x), 32'd50);
    check("hit_food_y", 32'(food_y), 32'd50);
    check("hit_err", 32'(place_err), 32'd0);

    // Retry exhaustion: x=630 is out of bounds for 16 samples.
    snake_len = '0; rX = 10'd630; rY = 10'd100;
    pulse_eat();
    for (int k = 1; k <= 14; k++) tick();
    check("err_before_15", 32'(place_err), 32'd0);
    tick();
    check("err_at_15", 32'(place_err), 32'd1);
    tick();
    check("err_sticky", 32'(place_err), 32'd1);
    check("err_busy", 32'(busy), 32'd1);
    rX = 10'd40;
    wait_placed("err", n);
    check("err_latency", 32'(n), 32'd2);
    check("err_cleared", 32'(place_err), 32'd0);
    check("err_food_x", 32'(food_x), 32'd40);
    check("err_food_y", 32'(food_y), 32'd100);

    // eat held through SAMPLE, SCAN and COMMIT is ignored: one placed pulse.
    snake_len = 6'd3; rX = 10'd200; rY = 10'd300;
    eat = 1'b1;
    tick();                       // eat edge from HOLD
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 6) eat = 1'b0;     // eat stays high through the COMMIT edge
      tick();
      if (placed) pulses++;
      check($sformatf("ign_busy%0d", k), 32'(busy), (k < 5) ? 32'd1 : 32'd0);
    end
    eat = 1'b0;
    check("ign_pulses", 32'(pulses), 32'd1);
    check("ign_valid", 32'(food_valid), 32'd1);
    check("ign_food_x", 32'(food_x), 32'd200);

    // Asynchronous reset in the middle of a scan, then placement restarts.
    snake_len = 6'd3; rX = 10'd300; rY = 10'd400;
    pulse_eat();
    tick(); tick();               // scanning segment 1
    rst_n = 1'b0;
    #1;
    check("midrst_food_x", 32'(food_x), 32'd320);
    check("midrst_food_y", 32'(food_y), 32'd240);
    check("midrst_valid", 32'(food_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_seg_idx", 32'(seg_idx), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_placed("midrst", n);
    check("midrst_latency", 32'(n), 32'd5);
    check("midrst_food_x2", 32'(food_x), 32'd300);
    check("midrst_food_y2", 32'(food_y), 32'd400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
